request_unit: RTL and testbench
===============================

# request_unit

Sequencer that sits directly upstream of the control unit in the multicycle MIPS datapath. It issues instruction-memory reads and latches the fetched word into the instruction register, which feeds the control unit's `instruction` input. It turns the control unit's decoded data read/write strobes into held memory requests that stay up until the memory acknowledges them. It also produces the PC/commit enable, a sticky halt, and a retired-instruction counter.

## Interface
Parameters:
- `WORD_W`, 32, width of the instruction word and of `instr_count` (matches `word_t`).

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low. One clock; this polarity and synchronicity are fixed.
- `ihit`  in  1  instruction memory read complete this cycle; `iload` is valid.
- `iload`  in  WORD_W  instruction word returned by memory.
- `dhit`  in  1  data memory access complete this cycle.
- `cu_dREN`  in  1  control unit `dREN` for the current instruction.
- `cu_dWEN`  in  1  control unit `dWEN` for the current instruction.
- `cu_halt`  in  1  control unit `halt` for the current instruction.
- `imemREN`  out  1  instruction memory read request.
- `dmemREN`  out  1  data memory read request.
- `dmemWEN`  out  1  data memory write request.
- `instruction`  out  WORD_W  instruction register, to the control unit.
- `pc_en`  out  1  one-cycle commit pulse: advance the PC and permit the register-file write.
- `halt`  out  1  sticky halt flag.
- `instr_count`  out  WORD_W  count of retired instructions.

## Operation
- FSM states: FETCH, EXEC, MEM, HALT. State resets to FETCH.
- FETCH:
  - `imemREN`=1.
  - On `ihit`: `instruction`<=`iload`, go to EXEC.
  - Without `ihit`: stay in FETCH; `instruction` holds its value.
- EXEC: the control unit decodes `instruction` combinationally. Evaluate in this priority order:
  - `cu_halt`=1: go to HALT, set `halt`<=1, `pc_en`=0, count not incremented. Halt wins over any `cu_dREN`/`cu_dWEN` seen in the same cycle.
  - `cu_dREN` or `cu_dWEN`: go to MEM, `pc_en`=0.
  - Otherwise: `pc_en`=1, `instr_count`+=1, go to FETCH.
- MEM:
  - `dmemWEN`=`cu_dWEN`.
  - `dmemREN`=`cu_dREN & ~cu_dWEN`. Write has priority if both are asserted; that combination is illegal but must not produce a dual request.
  - Requests are held every cycle until `dhit`.
  - On `dhit`: `pc_en`=1, `instr_count`+=1, go to FETCH.
- HALT:
  - All requests and `pc_en` are 0.
  - `halt` stays 1 and `instruction` is frozen.
  - Only `nRST` exits this state.
- Stray acknowledgements:
  - `ihit` outside FETCH is ignored; `instruction` does not change.
  - `dhit` outside MEM is ignored.
- `instr_count`:
  - Increments only when `pc_en`=1.
  - Wraps from 2^WORD_W−1 to 0 with no flag.

## Timing
- Registered outputs: state, `instruction`, `halt`, `instr_count`.
- Combinational outputs, decoded from state and `cu_*`: `imemREN`, `dmemREN`, `dmemWEN`, `pc_en`.
- Values after reset:
  - State FETCH.
  - `instruction`=0, `halt`=0, `instr_count`=0.
  - `imemREN`=1 (FETCH); `dmemREN`=`dmemWEN`=`pc_en`=0.
- Asserting `nRST` mid-operation drops all requests immediately, without waiting for a clock edge. An outstanding `dhit` or `ihit` then has no effect.
- Latency with zero-wait memory (`ihit`/`dhit` high in the first request cycle):
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load/store: 3 cycles (FETCH, EXEC, MEM).
- Each wait-state cycle adds 1 cycle in FETCH or MEM.
- `pc_en` is high for exactly one cycle per retired instruction.
- `imemREN` and `dmemREN`/`dmemWEN` are never high in the same cycle.

## Test plan
- Reset, then `ihit`=1 with `iload`=0x0022_0820 (ADD) and `cu_*`=0:
  - `instruction`=0x0022_0820 on the next edge.
  - EXEC cycle has `pc_en`=1.
  - `instr_count`=1; back in FETCH with `imemREN`=1.
- LW with `cu_dREN`=1 and `dhit` delayed 3 cycles:
  - `dmemREN` held high for 4 cycles, `dmemWEN`=0, `pc_en`=0 throughout.
  - `pc_en`=1 only in the `dhit` cycle.
- SW with `cu_dREN`=`cu_dWEN`=1 (illegal combination): `dmemWEN`=1 and `dmemREN`=0 for the whole MEM state.
- HALT opcode (`cu_halt`=1, with `cu_dWEN`=1 in the same EXEC cycle):
  - Enters HALT, `halt`=1, no memory request issued, `instr_count` unchanged.
  - Stays in HALT with all requests 0 for 20 further cycles despite toggling `ihit`/`dhit`.
- Drop `nRST` in the middle of a MEM wait: `dmemWEN` falls to 0 with no clock edge, and all outputs take their reset values.
- Preload `instr_count` to 0xFFFF_FFFF (forced), then retire one instruction: `instr_count`=0.

Source files
------------

// File: rtl/request_unit_if.sv
// Bundle between the request unit, the instruction/data memories and the control unit.
// master: the request unit; slave: the memory/control-unit side.
interface request_unit_if #(
    parameter int WORD_W = 32
);
    logic              ihit;
    logic [WORD_W-1:0] iload;
    logic              dhit;
    logic              cu_dREN;
    logic              cu_dWEN;
    logic              cu_halt;
    logic              imemREN;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] instruction;
    logic              pc_en;
    logic              halt;
    logic [WORD_W-1:0] instr_count;

    modport master (
        input  ihit, iload, dhit, cu_dREN, cu_dWEN, cu_halt,
        output imemREN, dmemREN, dmemWEN, instruction, pc_en, halt, instr_count
    );

    modport slave (
        output ihit, iload, dhit, cu_dREN, cu_dWEN, cu_halt,
        input  imemREN, dmemREN, dmemWEN, instruction, pc_en, halt, instr_count
    );
endinterface

// File: rtl/request_unit.sv
// Multicycle fetch/execute/memory sequencer feeding the control unit: holds memory
// requests until acknowledged, pulses pc_en on retirement and counts retired instructions.
//
// state | meaning
// FETCH | instruction read outstanding, IR loads on ihit
// EXEC  | control unit decodes IR; retire, go to MEM, or halt
// MEM   | data request held until dhit
// HALT  | everything idle until reset
module request_unit #(
    parameter int WORD_W = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    request_unit_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state;
    logic   mem_op;

    assign mem_op = bus.cu_dREN | bus.cu_dWEN;

    // Decoded from state so an async reset drops every request without a clock edge.
    // Write wins over read so an illegal dREN+dWEN never issues a dual request.
    assign bus.imemREN = (state == FETCH);
    assign bus.dmemWEN = (state == MEM) & bus.cu_dWEN;
    assign bus.dmemREN = (state == MEM) & bus.cu_dREN & ~bus.cu_dWEN;
    assign bus.pc_en   = ((state == EXEC) & ~bus.cu_halt & ~mem_op)
                       | ((state == MEM) & bus.dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= FETCH;
            bus.instruction <= '0;
            bus.halt        <= 1'b0;
            bus.instr_count <= '0;
        end else begin
            if (bus.pc_en) begin
                bus.instr_count <= bus.instr_count + WORD_W'(1);
            end
            case (state)
                FETCH: begin
                    if (bus.ihit) begin
                        bus.instruction <= bus.iload;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.cu_halt) begin
                        bus.halt <= 1'b1;
                        state    <= HALT;
                    end else if (mem_op) begin
                        state <= MEM;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (bus.dhit) begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: randomized instruction streams checked cycle by cycle
// against a transaction-level expectation of fetch, execute and memory phases.
module tb_request_unit;
    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_BOTH = 3;

    logic CLK = 1'b0;
    logic nRST;
    logic s_nrst;

    always #5 CLK = ~CLK;

    request_unit_if #(.WORD_W(32)) bus ();
    request_unit_if #(.WORD_W(8))  sbus ();

    request_unit #(.WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Narrow instance so counter wrap is reachable in a few hundred cycles.
    request_unit #(.WORD_W(8)) sdut (
        .CLK  (CLK),
        .nRST (s_nrst),
        .bus  (sbus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_instr;
    logic [31:0] exp_count;
    logic [4:0]  exp_flags;
    logic [4:0]  got_flags;

    assign got_flags = {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pc_en, bus.halt};

    task automatic run_instr(input int kind, input int iwait, input int dwait,
                             input logic [31:0] word);
        bit mem;
        mem = (kind != K_ALU);
        for (int k = 0; k <= iwait; k++) begin
            bus.ihit    = (k == iwait);
            bus.iload   = (k == iwait) ? word : $urandom;
            bus.dhit    = 1'($urandom_range(0, 1));
            bus.cu_dREN = 1'($urandom_range(0, 1));
            bus.cu_dWEN = 1'($urandom_range(0, 1));
            bus.cu_halt = 1'b0;
            @(negedge CLK);
            exp_flags = 5'b10000;
            n_checks++;
            if (got_flags !== exp_flags || bus.instruction !== exp_instr || bus.instr_count !== exp_count)
                $display("FAIL fetch: flags=%b instr=%h count=%0d, need flags=%b instr=%h count=%0d",
                         got_flags, bus.instruction, bus.instr_count, exp_flags, exp_instr, exp_count);
            else n_pass++;
            @(posedge CLK); #1;
            if (k == iwait) exp_instr = word;
        end
        bus.ihit    = 1'($urandom_range(0, 1));
        bus.iload   = $urandom;
        bus.dhit    = 1'($urandom_range(0, 1));
        bus.cu_halt = 1'b0;
        bus.cu_dREN = (kind == K_LW) || (kind == K_BOTH);
        bus.cu_dWEN = (kind == K_SW) || (kind == K_BOTH);
        @(negedge CLK);
        exp_flags = {3'b000, !mem, 1'b0};
        n_checks++;
        if (got_flags !== exp_flags || bus.instruction !== exp_instr || bus.instr_count !== exp_count)
            $display("FAIL exec: flags=%b instr=%h count=%0d, need flags=%b instr=%h count=%0d",
                     got_flags, bus.instruction, bus.instr_count, exp_flags, exp_instr, exp_count);
        else n_pass++;
        @(posedge CLK); #1;
        if (!mem) exp_count = exp_count + 1;
        if (mem) begin
            for (int k = 0; k <= dwait; k++) begin
                bus.dhit  = (k == dwait);
                bus.ihit  = 1'($urandom_range(0, 1));
                bus.iload = $urandom;
                @(negedge CLK);
                exp_flags = {1'b0, kind == K_LW, kind != K_LW, k == dwait, 1'b0};
                n_checks++;
                if (got_flags !== exp_flags || bus.instruction !== exp_instr || bus.instr_count !== exp_count)
                    $display("FAIL mem: flags=%b instr=%h count=%0d, need flags=%b instr=%h count=%0d",
                             got_flags, bus.instruction, bus.instr_count, exp_flags, exp_instr, exp_count);
                else n_pass++;
                @(posedge CLK); #1;
                if (k == dwait) exp_count = exp_count + 1;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.ihit = 1'b1;
        bus.iload = 32'hDEAD_BEEF;
        bus.dhit = 1'b1;
        bus.cu_dREN = 1'b1;
        bus.cu_dWEN = 1'b1;
        bus.cu_halt = 1'b0;
        @(posedge CLK); #3;
        n_checks++;
        if (got_flags !== 5'b10000 || bus.instruction !== 32'h0 || bus.instr_count !== 32'h0)
            $display("FAIL reset: flags=%b instr=%h count=%0d, need flags=10000 instr=0 count=0",
                     got_flags, bus.instruction, bus.instr_count);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        bus.ihit = 1'b0;
        exp_instr = 32'h0;
        exp_count = 32'h0;
        @(posedge CLK); #1;
    endtask

    task automatic test_add();
        run_instr(K_ALU, 0, 0, 32'h0022_0820);
        bus.ihit = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (got_flags !== 5'b10000 || bus.instruction !== 32'h0022_0820 || bus.instr_count !== 32'd1)
            $display("FAIL add: flags=%b instr=%h count=%0d, need flags=10000 instr=00220820 count=1",
                     got_flags, bus.instruction, bus.instr_count);
        else n_pass++;
        @(posedge CLK); #1;
    endtask

    task automatic test_load();
        run_instr(K_LW, 0, 3, 32'h8C22_0004);
        run_instr(K_LW, 2, 0, $urandom);
    endtask

    task automatic test_store_illegal();
        run_instr(K_SW, 0, 0, 32'hAC22_0004);
        run_instr(K_BOTH, 1, 2, $urandom);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom);
        end
    endtask

    task automatic test_halt();
        logic [31:0] word;
        word = 32'hFC00_0000;
        bus.ihit = 1'b1;
        bus.iload = word;
        bus.cu_halt = 1'b0;
        @(posedge CLK); #1;
        exp_instr = word;
        bus.ihit = 1'b0;
        bus.cu_halt = 1'b1;
        bus.cu_dWEN = 1'b1;
        bus.cu_dREN = 1'($urandom_range(0, 1));
        @(negedge CLK);
        n_checks++;
        if (got_flags !== 5'b00000)
            $display("FAIL halt_exec: flags=%b, need 00000", got_flags);
        else n_pass++;
        @(posedge CLK); #1;
        for (int i = 0; i < 20; i++) begin
            bus.ihit    = i[0];
            bus.dhit    = ~i[0];
            bus.iload   = $urandom;
            bus.cu_dREN = 1'($urandom_range(0, 1));
            bus.cu_dWEN = 1'($urandom_range(0, 1));
            bus.cu_halt = 1'($urandom_range(0, 1));
            @(negedge CLK);
            n_checks++;
            if (got_flags !== 5'b00001 || bus.instruction !== exp_instr || bus.instr_count !== exp_count)
                $display("FAIL halt_hold: flags=%b instr=%h count=%0d, need flags=00001 instr=%h count=%0d",
                         got_flags, bus.instruction, bus.instr_count, exp_instr, exp_count);
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        exp_instr = 32'h0;
        exp_count = 32'h0;
        bus.cu_halt = 1'b0;
        bus.cu_dREN = 1'b0;
        bus.cu_dWEN = 1'b1;
        bus.dhit = 1'b0;
        bus.ihit = 1'b1;
        bus.iload = 32'hAC01_0010;
        @(posedge CLK); #1;
        bus.ihit = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if (got_flags !== 5'b00100)
            $display("FAIL mem_wait: flags=%b, need 00100", got_flags);
        else n_pass++;
        @(posedge CLK); #3;
        nRST = 1'b0;
        bus.dhit = 1'b1;
        #1;
        n_checks++;
        if (got_flags !== 5'b10000 || bus.instruction !== 32'h0 || bus.instr_count !== 32'h0)
            $display("FAIL async_reset: flags=%b instr=%h count=%0d, need flags=10000 instr=0 count=0",
                     got_flags, bus.instruction, bus.instr_count);
        else n_pass++;
        @(posedge CLK); #1;
        n_checks++;
        if (got_flags !== 5'b10000 || bus.instr_count !== 32'h0)
            $display("FAIL reset_dhit: flags=%b count=%0d, need flags=10000 count=0",
                     got_flags, bus.instr_count);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        bus.dhit = 1'b0;
        @(posedge CLK); #1;
        run_instr(K_ALU, 1, 0, $urandom);
    endtask

    task automatic test_wrap();
        int n;
        @(negedge CLK);
        s_nrst = 1'b1;
        n = 0;
        for (int target = 255; target <= 257; target++) begin
            repeat (2 * (target - n)) @(posedge CLK);
            #1;
            n = target;
            n_checks++;
            if (sbus.instr_count !== 8'(n % 256))
                $display("FAIL wrap: count=%0d after %0d retirements, need %0d",
                         sbus.instr_count, n, n % 256);
            else n_pass++;
        end
    endtask

    initial begin
        s_nrst = 1'b0;
        sbus.ihit = 1'b1;
        sbus.iload = 32'h0;
        sbus.dhit = 1'b0;
        sbus.cu_dREN = 1'b0;
        sbus.cu_dWEN = 1'b0;
        sbus.cu_halt = 1'b0;
        test_reset();
        test_add();
        test_load();
        test_store_illegal();
        test_random();
        test_halt();
        test_reset_mid_mem();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
